// File: rtl/writeback_stage_if.sv
//------------------------------------------------------------------------------
// Interface : writeback_stage_if
// Purpose   : Bundles the memory-stage input bus and the register-file write
//             port of the writeback stage.
// Modports  : slave  - seen by writeback_stage (consumes W-side, drives O-side)
//             master - seen by the surrounding pipeline / testbench
// Signals   : ValidW/ReadyW handshake, RegWriteW, RdW, ResultSrcW, Funct3W,
//             ALU_ResultW, ReadDataW, PCPlus4W, ImmExtW (memory stage side);
//             RegWriteO, RdO, ResultO, WbValidO, RfReadyI, InstretO
//             (register-file side).
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface writeback_stage_if #(
  parameter int XLEN = 32,
  parameter int CNTW = 64
);
  logic            ValidW;
  logic            ReadyW;
  logic            RegWriteW;
  logic [4:0]      RdW;
  logic [1:0]      ResultSrcW;
  logic [2:0]      Funct3W;
  logic [XLEN-1:0] ALU_ResultW;
  logic [XLEN-1:0] ReadDataW;
  logic [XLEN-1:0] PCPlus4W;
  logic [XLEN-1:0] ImmExtW;
  logic            RegWriteO;
  logic [4:0]      RdO;
  logic [XLEN-1:0] ResultO;
  logic            WbValidO;
  logic            RfReadyI;
  logic [CNTW-1:0] InstretO;

  modport slave (
    input  ValidW, RegWriteW, RdW, ResultSrcW, Funct3W,
           ALU_ResultW, ReadDataW, PCPlus4W, ImmExtW, RfReadyI,
    output ReadyW, RegWriteO, RdO, ResultO, WbValidO, InstretO
  );

  modport master (
    output ValidW, RegWriteW, RdW, ResultSrcW, Funct3W,
           ALU_ResultW, ReadDataW, PCPlus4W, ImmExtW, RfReadyI,
    input  ReadyW, RegWriteO, RdO, ResultO, WbValidO, InstretO
  );
endinterface

`default_nettype wire

// File: rtl/writeback_stage.sv
//------------------------------------------------------------------------------
// Module    : writeback_stage
// Purpose   : Selects the writeback result (ALU / extended load / PC+4 /
//             immediate), buffers {wr, rd, result} in a DEPTH-entry FIFO and
//             drains it to the register-file write port under valid/ready.
// Ports     : clk  - clock, rising edge
//             rst  - asynchronous reset, active-low
//             wb   - writeback_stage_if.slave (memory-stage bus + RF port)
// Options   : WB_INSTRET_EN - when defined, InstretO counts every pop;
//             otherwise InstretO is tied to zero.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module writeback_stage #(
  parameter int XLEN  = 32,  // must be 32: load lanes are RV32 byte/half lanes
  parameter int DEPTH = 2,   // power of two, >= 2
  parameter int CNTW  = 64
) (
  input  wire logic         clk,
  input  wire logic         rst,
  writeback_stage_if.slave  wb
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);

  logic [AW:0]     r_count;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic            r_wr_mem  [DEPTH];
  logic [4:0]      r_rd_mem  [DEPTH];
  logic [XLEN-1:0] r_res_mem [DEPTH];

  logic            w_ready;
  logic            w_valid;
  logic            w_push;
  logic            w_pop;
  logic            w_wr;
  logic [1:0]      w_off;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_result;

  assign w_ready = (r_count < C_DEPTH);
  assign w_valid = (r_count != '0);
  assign w_push  = wb.ValidW & w_ready;
  assign w_pop   = w_valid & wb.RfReadyI;
  // x0 is never written, but the entry still retires through the buffer.
  assign w_wr    = wb.RegWriteW & (wb.RdW != 5'd0);

  // Load lane extraction; halfword selection ignores the low offset bit.
  always_comb begin
    w_off  = wb.ALU_ResultW[1:0];
    w_byte = wb.ReadDataW[7:0];
    case (w_off)
      2'd0:    w_byte = wb.ReadDataW[7:0];
      2'd1:    w_byte = wb.ReadDataW[15:8];
      2'd2:    w_byte = wb.ReadDataW[23:16];
      default: w_byte = wb.ReadDataW[31:24];
    endcase
    w_half = w_off[1] ? wb.ReadDataW[31:16] : wb.ReadDataW[15:0];
    case (wb.Funct3W)
      3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
      3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
      default: w_load = wb.ReadDataW;
    endcase
  end

  always_comb begin
    w_result = wb.ALU_ResultW;
    case (wb.ResultSrcW)
      2'b00:   w_result = wb.ALU_ResultW;
      2'b01:   w_result = w_load;
      2'b10:   w_result = wb.PCPlus4W;
      default: w_result = wb.ImmExtW;
    endcase
  end

  // Pointer/occupancy state; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wr_mem[r_wr_ptr]  <= w_wr;
      r_rd_mem[r_wr_ptr]  <= wb.RdW;
      r_res_mem[r_wr_ptr] <= w_result;
    end
  end

  assign wb.ReadyW    = w_ready;
  assign wb.WbValidO  = w_valid;
  assign wb.RegWriteO = w_valid & r_wr_mem[r_rd_ptr];
  assign wb.RdO       = w_valid ? r_rd_mem[r_rd_ptr]  : 5'd0;
  assign wb.ResultO   = w_valid ? r_res_mem[r_rd_ptr] : '0;

`ifdef WB_INSTRET_EN
  logic [CNTW-1:0] r_instret;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instret <= '0;
    end else if (w_pop) begin
      r_instret <= r_instret + CNTW'(1);
    end
  end

  assign wb.InstretO = r_instret;
`else
  assign wb.InstretO = '0;
`endif

endmodule

`default_nettype wire
